// File: rtl/sha256_sched_ctrl_pkg.sv
// rtl/sha256_sched_ctrl_pkg.sv - shared state encoding, sizes and SHA-256 IV for the block sequencer
package sha256_pkg;

  localparam int ROUNDS = 64;
  localparam int RIDX_W = $clog2(ROUNDS);
  localparam logic [RIDX_W-1:0] LAST_ROUND = 6'd63;
  localparam int BLK_W = 512;

  // Initial hash value, also consumed by the compression datapath
  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/sha256_sched_ctrl_if.sv
// rtl/sha256_sched_ctrl_if.sv - padded-block handshake between block source and sequencer
interface sha256_sched_ctrl_if;
  import sha256_pkg::*;

  logic             blk_valid;
  logic             blk_ready;
  logic [BLK_W-1:0] blk_data;
  logic             blk_first;
  logic             blk_last;

  modport master (
    output blk_valid, blk_data, blk_first, blk_last,
    input  blk_ready
  );

  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last,
    output blk_ready
  );

endinterface

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - round index counter with explicit 63->0 wrap
module sha256_round_cnt
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [RIDX_W-1:0] idx,
  output logic              is_last
);

  assign is_last = (idx == LAST_ROUND);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_sched_ctrl.sv
// rtl/sha256_sched_ctrl.sv - SHA-256 per-block sequencer: load, 64 rounds, accumulate, digest
// Optional SHA_SCHED_STALL_EN adds a round_stall input that freezes the round index.
module sha256_sched_ctrl
  import sha256_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sha256_sched_ctrl_if.slave   blk,
`ifdef SHA_SCHED_STALL_EN
  input  logic                 round_stall,
`endif
  output logic [BLK_W-1:0]     ms_data,
  output logic                 ms_load,
  output logic [RIDX_W-1:0]    round_idx,
  output logic                 round_en,
  output logic                 round_last,
  output logic                 hv_init,
  output logic                 hv_accum,
  output logic                 digest_valid,
  output logic                 busy
);

`ifndef SHA_SCHED_STALL_EN
  logic round_stall;
  assign round_stall = 1'b0;
`endif

  state_t state;
  logic   last_q;
  logic   cnt_last;

  // Ready and busy decode only the state register, so blk_valid never reaches blk_ready
  assign blk.blk_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign round_en      = (state == ROUND) && !round_stall;
  assign round_last    = round_en && cnt_last;

  sha256_round_cnt u_round_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ROUND),
    .en      (round_en),
    .idx     (round_idx),
    .is_last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ms_data      <= '0;
      last_q       <= 1'b0;
      ms_load      <= 1'b0;
      hv_init      <= 1'b0;
      hv_accum     <= 1'b0;
      digest_valid <= 1'b0;
    end else begin
      ms_load      <= 1'b0;
      hv_init      <= 1'b0;
      hv_accum     <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (blk.blk_valid) begin
            ms_data <= blk.blk_data;
            last_q  <= blk.blk_last;
            ms_load <= 1'b1;
            hv_init <= blk.blk_first;
            state   <= LOAD;
          end
        end
        LOAD: state <= ROUND;
        ROUND: begin
          if (round_en && cnt_last) begin
            hv_accum <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (last_q) begin
            digest_valid <= 1'b1;
            state        <= DONE;
          end else begin
            state <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// tb/tb_sha256_sched_ctrl.sv - self-checking bench for sha256_sched_ctrl with a per-block timeline model
module tb_sha256_sched_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic round_stall = 1'b0;
  always #5 clk = ~clk;

  sha256_sched_ctrl_if bif ();

  logic [511:0] ms_data;
  logic [5:0]   round_idx;
  logic ms_load, round_en, round_last, hv_init, hv_accum, digest_valid, busy;

  sha256_sched_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .blk          (bif),
`ifdef SHA_SCHED_STALL_EN
    .round_stall  (round_stall),
`endif
    .ms_data      (ms_data),
    .ms_load      (ms_load),
    .round_idx    (round_idx),
    .round_en     (round_en),
    .round_last   (round_last),
    .hv_init      (hv_init),
    .hv_accum     (hv_accum),
    .digest_valid (digest_valid),
    .busy         (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: a block's outputs are a fixed timeline measured from its handshake cycle
  bit           checking = 0;
  bit           active = 0;
  bit           m_first = 0;
  bit           m_last = 0;
  int           hs = 0;
  int           stalls = 0;
  logic [511:0] exp_ms = '0;

  int load_cnt = 0, init_cnt = 0, acc_cnt = 0, dv_cnt = 0, rlast_cnt = 0;
  int load_cyc = 0, prev_load_cyc = 0, acc_cyc = 0, dv_cyc = 0;

  always @(negedge clk) begin
    int         eff;
    bit         in_rnd;
    bit         e_ren;
    logic [5:0] e_idx;
    eff = cyc - hs - stalls;
    if (active && eff >= (m_last ? 68 : 67)) active = 0;
    in_rnd = active && eff >= 2 && eff <= 65;
    e_ren  = in_rnd && !round_stall;
    e_idx  = in_rnd ? 6'(eff - 2) : 6'd0;
    if (checking) begin
      chk("blk_ready",    bif.blk_ready, !active);
      chk("busy",         busy,          active);
      chk("ms_load",      ms_load,       active && eff == 1);
      chk("hv_init",      hv_init,       active && eff == 1 && m_first);
      chk("round_en",     round_en,      e_ren);
      chk("round_idx",    round_idx,     e_idx);
      chk("round_last",   round_last,    e_ren && e_idx == 6'd63);
      chk("hv_accum",     hv_accum,      active && eff == 66);
      chk("digest_valid", digest_valid,  active && eff == 67 && m_last);
      chk("ms_data",      ms_data,       exp_ms);
    end
    if (ms_load === 1'b1) begin load_cnt++; prev_load_cyc = load_cyc; load_cyc = cyc; end
    if (hv_init === 1'b1) init_cnt++;
    if (hv_accum === 1'b1) begin acc_cnt++; acc_cyc = cyc; end
    if (digest_valid === 1'b1) begin dv_cnt++; dv_cyc = cyc; end
    if (round_last === 1'b1) rlast_cnt++;
    if (rst) begin
      active = 0;
      exp_ms = '0;
      stalls = 0;
    end else if (!active && bif.blk_valid) begin
      active  = 1;
      hs      = cyc;
      m_first = bif.blk_first;
      m_last  = bif.blk_last;
      exp_ms  = bif.blk_data;
      stalls  = 0;
    end else if (in_rnd && round_stall) begin
      stalls++;
    end
  end

  task automatic send(logic [511:0] d, bit f, bit l);
    int n = 0;
    bif.blk_valid = 1'b1;
    bif.blk_data  = d;
    bif.blk_first = f;
    bif.blk_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.blk_ready && n < 200);
    if (bif.blk_ready !== 1'b1) chk("send_timeout", bif.blk_ready, 1'b1);
    @(posedge clk);
    #1;
    bif.blk_valid = 1'b0;
    bif.blk_first = 1'b0;
    bif.blk_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (active && n < 300);
    if (active) chk("idle_timeout", active, 1'b0);
    @(posedge clk);
    #1;
  endtask

  logic [511:0] abc;
  int a0, d0, i0, l0, r0;

  initial begin
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
    bif.blk_valid = 1'b0;
    bif.blk_data  = '0;
    bif.blk_first = 1'b0;
    bif.blk_last  = 1'b0;

    // Reset values
    @(posedge clk);
    #1 checking = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   bif.blk_ready, 1'b1);
    chk("rst_busy",    busy,          1'b0);
    chk("rst_idx",     round_idx,     6'd0);
    chk("rst_ms_data", ms_data,       '0);
    chk("rst_dv",      digest_valid,  1'b0);
    rst = 1'b0;

    // Single block "abc"
    send(abc, 1'b1, 1'b1);
    wait_idle();
    chk("abc_load_lat",  load_cyc - hs, 1);
    chk("abc_accum_lat", acc_cyc - hs,  66);
    chk("abc_dv_lat",    dv_cyc - hs,   67);
    chk("abc_init_cnt",  init_cnt,      1);
    chk("abc_ms_data",   ms_data,       abc);

    // Two-block message
    i0 = init_cnt;
    d0 = dv_cnt;
    send({16{32'h11111111}}, 1'b1, 1'b0);
    wait_idle();
    chk("b1_no_dv",     dv_cnt,       d0);
    chk("b1_accum_lat", acc_cyc - hs, 66);
    send({16{32'h22222222}}, 1'b0, 1'b1);
    wait_idle();
    chk("b2_dv_lat",    dv_cyc - hs,  67);
    chk("b2_init_once", init_cnt,     i0 + 1);
    chk("b2_dv_once",   dv_cnt,       d0 + 1);

    // blk_valid held high with data changing every cycle
    l0 = load_cnt;
    bif.blk_valid = 1'b1;
    bif.blk_data  = {16{32'hcafef00d}};
    repeat (140) begin
      @(posedge clk);
      #1 bif.blk_data = {16{$urandom}};
    end
    bif.blk_valid = 1'b0;
    wait_idle();
    chk("stream_loads",   load_cnt - l0,            3);
    chk("stream_spacing", load_cyc - prev_load_cyc, 67);

    // Reset while round_idx == 30
    a0 = acc_cnt;
    d0 = dv_cnt;
    send(abc, 1'b1, 1'b1);
    repeat (31) @(posedge clk);
    #1 chk("pre_rst_idx", round_idx, 6'd30);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_ready",    bif.blk_ready, 1'b1);
    chk("midrst_round_en", round_en,      1'b0);
    chk("midrst_busy",     busy,          1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_accum", acc_cnt, a0);
    chk("midrst_no_dv",    dv_cnt,  d0);
    send(abc, 1'b1, 1'b1);
    wait_idle();
    chk("post_rst_dv_lat", dv_cyc - hs, 67);

`ifdef SHA_SCHED_STALL_EN
    // Stall five cycles on the final round
    r0 = rlast_cnt;
    send(abc, 1'b1, 1'b1);
    repeat (64) @(posedge clk);
    #1 round_stall = 1'b1;
    chk("stall_idx", round_idx, 6'd63);
    repeat (5) @(posedge clk);
    #1 round_stall = 1'b0;
    wait_idle();
    chk("stall_accum_lat",  acc_cyc - hs,     71);
    chk("stall_rlast_once", rlast_cnt - r0,   1);
`else
    r0 = rlast_cnt;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
